// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one registered-in/registered-out multiplier
// among NUM_REQ requesters with per-requester valid/ready channels.
module multiplier_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P
);
  generate
    if (IMPL_TYPE == 0) begin : g_shift_add
      // Explicit shift-and-add chain; only the low WIDTH bits are kept.
      always_comb begin
        P = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (B[i]) P = P + (A << i);
        end
      end
    end else begin : g_operator
      assign P = A * B;
    end
  endgenerate
endmodule

// state   | meaning
// IDLE    | arbitrate, accept one request and latch its operands
// COMPUTE | multiplier output captured into resp_P
// RESP    | resp_valid to the granted requester until it accepts
module mult_share_ctrl #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0,
  parameter int NUM_REQ   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_A,
  input  logic [NUM_REQ*WIDTH-1:0] req_B,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_P,
  output logic                     busy,
  output logic [15:0]              done_cnt
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant, pick;
  logic [IDX_W:0]   idx_sum;
  logic             pick_vld, accept, resp_done;
  logic [WIDTH-1:0] op_A, op_B, mult_P;

  multiplier_nbit #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_mult (
    .A(op_A),
    .B(op_B),
    .P(mult_P)
  );

  // Scan offsets from the far end so the one closest to rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx_sum  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (idx_sum >= (IDX_W + 1)'(NUM_REQ)) idx_sum = idx_sum - (IDX_W + 1)'(NUM_REQ);
      if (req_valid[idx_sum[IDX_W-1:0]]) begin
        pick     = idx_sum[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by rst_n so it drops the moment reset asserts.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    resp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && rst_n) begin
          req_ready[pick] = 1'b1;
          accept          = 1'b1;
          state_nxt       = COMPUTE;
        end
      end
      COMPUTE: state_nxt = RESP;
      RESP: begin
        resp_valid[grant] = 1'b1;
        if (resp_ready[grant]) begin
          resp_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_A     <= '0;
      op_B     <= '0;
      resp_P   <= '0;
      done_cnt <= '0;
      grant    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (accept) begin
        op_A  <= req_A[pick*WIDTH +: WIDTH];
        op_B  <= req_B[pick*WIDTH +: WIDTH];
        grant <= pick;
      end
      if (state == COMPUTE) resp_P <= mult_P;
      if (resp_done) begin
        done_cnt <= done_cnt + 16'd1;
        rr_ptr   <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
    end
  end
endmodule
